// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Takes the M-stage effective address and decoded op, runs one req/gnt/rvalid
// transaction on the data-memory port, and freezes the pipeline while it is
// outstanding. Produces byte enables, lane-replicated write data and the
// sign/zero-extended load result for the W stage.
//
// Handshake: dmem_req_o is held high, with addr/we/be/wdata stable, until a cycle
// in which dmem_gnt_i is also high; that cycle is the transfer. For loads, the
// read data is taken in the first WAIT cycle that sees dmem_rvalid_i; rvalid seen
// in any other state is dropped.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m_valid_i,
    input  logic        m_is_load_i,
    input  logic        m_is_store_i,
    input  logic [1:0]  m_size_i,
    input  logic        m_unsigned_i,
    input  logic [31:0] m_alu_data_i,
    input  logic [31:0] m_store_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        lsu_err_o,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic [1:0]  dbg_state_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    // Counter value in the last cycle allowed without progress.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_uns;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic          r_load_valid;
    logic [31:0]   r_load_data;

    logic [1:0]    w_off;
    logic          w_any_op;
    logic          w_both_op;
    logic          w_bad_size;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_error;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rshift;
    logic [31:0]   w_ext;

    // Decode the incoming M-stage op: legality, byte enables and write data.
    always_comb begin
        w_off        = m_alu_data_i[1:0];
        w_any_op     = m_is_load_i | m_is_store_i;
        w_both_op    = m_is_load_i & m_is_store_i;
        w_bad_size   = (m_size_i == 2'b11);
        w_misaligned = ((m_size_i == 2'b01) & w_off[0]) |
                       ((m_size_i == 2'b10) & (w_off != 2'b00));
        w_accept     = m_valid_i & (m_is_load_i ^ m_is_store_i) & ~w_bad_size & ~w_misaligned;
        // Illegal shapes only matter when the op actually touches memory.
        w_error      = m_valid_i & (w_both_op | (w_any_op & (w_bad_size | w_misaligned)));
        w_be         = 4'b1111;
        w_wdata      = m_store_data_i;
        case (m_size_i)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{m_store_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{m_store_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = m_store_data_i;
            end
        endcase
    end

    // Extract and extend the addressed lane of the returning read data.
    always_comb begin
        // Halves and words are aligned, so shifting by the byte offset also
        // lands them at bit 0.
        w_rshift = dmem_rdata_i >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_rshift[7]}}, w_rshift[7:0]};
            2'b01:   w_ext = {{16{~r_uns & w_rshift[15]}}, w_rshift[15:0]};
            default: w_ext = dmem_rdata_i;
        endcase
    end

    // Transaction FSM with latched request fields, timeout counter and result pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_err        <= 1'b0;
            r_load_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_addr  <= {m_alu_data_i[31:2], 2'b00};
                        r_off   <= w_off;
                        r_size  <= m_size_i;
                        r_uns   <= m_unsigned_i;
                        r_we    <= m_is_store_i;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_state <= S_REQ;
                    end else if (w_error) begin
                        r_err <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= r_we ? S_DONE : S_WAIT;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_cnt        <= '0;
                        r_load_data  <= w_ext;
                        r_load_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall covers the accept cycle (combinational) plus every REQ/WAIT cycle.
    always_comb begin
        stall_o = ((r_state == S_IDLE) & w_accept) | (r_state == S_REQ) | (r_state == S_WAIT);
    end

    assign dmem_req_o   = (r_state == S_REQ);
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;
    assign lsu_err_o    = r_err;
    assign load_valid_o = r_load_valid;
    assign load_data_o  = r_load_data;
    assign dbg_state_o  = r_state;

endmodule
